// File: rtl/seg_disp_pkg.sv
// rtl/seg_disp_pkg.sv - shared constants and helpers for the seven-segment display path
package seg_disp_pkg;

  localparam int MAX_DIGITS = 8;

  // Common-anode display: anodes are active-low, so all ones is dark.
  localparam logic [MAX_DIGITS-1:0] AN_OFF = {MAX_DIGITS{1'b1}};

  // Cathode pattern with every segment and the DP off.
  localparam logic [7:0] CA_BLANK = 8'hFF;

  // Counter width for a digit index; a single digit still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Bit i set when digit i is a leading zero: i is not the rightmost digit and
  // every nibble from i up to the most significant displayed digit is zero.
  function automatic logic [MAX_DIGITS-1:0] lzb_mask(input logic [4*MAX_DIGITS-1:0] value,
                                                     input int n);
    logic [MAX_DIGITS-1:0] mask;
    logic                  all_zero;
    mask     = '0;
    all_zero = 1'b1;
    for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
      if (i < n) begin
        all_zero = all_zero & (value[4*i +: 4] == 4'h0);
        if (i != 0) mask[i] = all_zero;
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/seven_seg_scan_mux_if.sv
// rtl/seven_seg_scan_mux_if.sv - load and display signal bundle for the scan mux
interface seven_seg_scan_mux_if #(
  parameter int NUM_DIGITS = 8
);

  logic [4*NUM_DIGITS-1:0] Value_I;
  logic                    Load_I;
  logic [NUM_DIGITS-1:0]   DpMask_I;
  logic [NUM_DIGITS-1:0]   DigitEn_I;
  logic                    LzbEn_I;
  logic [3:0]              HexDigit_O;
  logic                    Dp_O;
  logic [NUM_DIGITS-1:0]   Led_AN_O;
  logic                    Frame_O;

  modport master (
    output Value_I, Load_I, DpMask_I, DigitEn_I, LzbEn_I,
    input  HexDigit_O, Dp_O, Led_AN_O, Frame_O
  );

  modport slave (
    input  Value_I, Load_I, DpMask_I, DigitEn_I, LzbEn_I,
    output HexDigit_O, Dp_O, Led_AN_O, Frame_O
  );

endinterface

// File: rtl/seg_scan_timer.sv
// rtl/seg_scan_timer.sv - slot tick and digit index counters for the scan mux
module seg_scan_timer
  import seg_disp_pkg::*;
#(
  parameter int NUM_DIGITS      = 8,
  parameter int TICKS_PER_DIGIT = 100000,
  parameter int BLANK_TICKS     = 1000,
  parameter int TICK_W          = $clog2(TICKS_PER_DIGIT),
  parameter int IDX_W           = idx_width(NUM_DIGITS)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             slot_start_o,
  output logic             blank_win_o,
  output logic             frame_wrap_o
);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_DIGIT - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  logic [TICK_W-1:0] tick_q, tick_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              slot_end;

  // Tick wraps every slot; the digit index steps on the last tick of a slot.
  always_comb begin
    slot_end = (tick_q == TICK_LAST);
    tick_d   = slot_end ? '0 : tick_q + 1'b1;
    idx_d    = idx_q;
    if (slot_end) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
  end

  // Counter registers, cleared together so no partial slot survives a reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tick_q <= '0;
      idx_q  <= '0;
    end else begin
      tick_q <= tick_d;
      idx_q  <= idx_d;
    end
  end

  assign idx_o        = idx_q;
  assign slot_start_o = (tick_q == '0);
  assign frame_wrap_o = slot_end && (idx_q == IDX_LAST);

  if (BLANK_TICKS == 0) begin : g_no_blank
    assign blank_win_o = 1'b0;
  end else begin : g_blank
    assign blank_win_o = (tick_q < TICK_W'(BLANK_TICKS));
  end

endmodule

// File: rtl/seven_seg_scan_mux.sv
// rtl/seven_seg_scan_mux.sv - double-buffered multi-digit scan mux for a common-anode display
module seven_seg_scan_mux
  import seg_disp_pkg::*;
#(
  parameter int NUM_DIGITS      = 8,
  parameter int TICKS_PER_DIGIT = 100000,
  parameter int BLANK_TICKS     = 1000
) (
  input  logic                Clk_I,
  input  logic                Rst_I,
  seven_seg_scan_mux_if.slave bus
);

  localparam int IDX_W = idx_width(NUM_DIGITS);
  localparam logic [NUM_DIGITS-1:0] AN_IDLE = AN_OFF[NUM_DIGITS-1:0];

  if (NUM_DIGITS < 1 || NUM_DIGITS > MAX_DIGITS) begin : g_bad_digits
    $error("seven_seg_scan_mux: NUM_DIGITS must be 1..8");
  end
  if (TICKS_PER_DIGIT < 2) begin : g_bad_ticks
    $error("seven_seg_scan_mux: TICKS_PER_DIGIT must be >= 2");
  end
  if (BLANK_TICKS < 0 || BLANK_TICKS >= TICKS_PER_DIGIT) begin : g_bad_blank
    $error("seven_seg_scan_mux: BLANK_TICKS must be 0..TICKS_PER_DIGIT-1");
  end

  logic [IDX_W-1:0] idx;
  logic             slot_start, blank_win, frame_wrap;

  seg_scan_timer #(
    .NUM_DIGITS     (NUM_DIGITS),
    .TICKS_PER_DIGIT(TICKS_PER_DIGIT),
    .BLANK_TICKS    (BLANK_TICKS),
    .IDX_W          (IDX_W)
  ) u_timer (
    .clk_i       (Clk_I),
    .rst_i       (Rst_I),
    .idx_o       (idx),
    .slot_start_o(slot_start),
    .blank_win_o (blank_win),
    .frame_wrap_o(frame_wrap)
  );

  logic [4*NUM_DIGITS-1:0] sh_val_q, sh_val_d, act_val_q, act_val_d;
  logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d, act_dp_q, act_dp_d;
  logic [NUM_DIGITS-1:0]   sh_en_q, sh_en_d, act_en_q, act_en_d;
  logic [3:0]              hex_q, hex_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    frame_q;

  logic [4*MAX_DIGITS-1:0] val_pad;
  logic [MAX_DIGITS-1:0]   dp_pad, en_pad, lzb, an_full;
  logic                    an_on;

  // Shadow takes every load; active only changes at the frame wrap, where a
  // coincident load bypasses the shadow so it shows in the frame just starting.
  always_comb begin
    sh_val_d  = sh_val_q;
    sh_dp_d   = sh_dp_q;
    sh_en_d   = sh_en_q;
    act_val_d = act_val_q;
    act_dp_d  = act_dp_q;
    act_en_d  = act_en_q;
    if (bus.Load_I) begin
      sh_val_d = bus.Value_I;
      sh_dp_d  = bus.DpMask_I;
      sh_en_d  = bus.DigitEn_I;
    end
    if (frame_wrap) begin
      act_val_d = bus.Load_I ? bus.Value_I   : sh_val_q;
      act_dp_d  = bus.Load_I ? bus.DpMask_I  : sh_dp_q;
      act_en_d  = bus.Load_I ? bus.DigitEn_I : sh_en_q;
    end
  end

  // Next display outputs from the current slot; the nibble is latched at slot
  // start so it is settled before the anode leaves the blanking window.
  always_comb begin
    val_pad                   = '0;
    val_pad[4*NUM_DIGITS-1:0] = act_val_q;
    dp_pad                    = '0;
    dp_pad[NUM_DIGITS-1:0]    = act_dp_q;
    en_pad                    = '0;
    en_pad[NUM_DIGITS-1:0]    = act_en_q;
    lzb     = bus.LzbEn_I ? lzb_mask(val_pad, NUM_DIGITS) : '0;
    an_on   = !blank_win && en_pad[idx] && !lzb[idx];
    an_full = AN_OFF;
    if (an_on) an_full[idx] = 1'b0;
    an_d    = an_full[NUM_DIGITS-1:0];
    dp_d    = dp_pad[idx] & an_on;
    hex_d   = slot_start ? val_pad[{idx, 2'b00} +: 4] : hex_q;
  end

  // Buffer and output registers.
  always_ff @(posedge Clk_I) begin
    if (Rst_I) begin
      sh_val_q  <= '0;
      sh_dp_q   <= '0;
      sh_en_q   <= '0;
      act_val_q <= '0;
      act_dp_q  <= '0;
      act_en_q  <= '0;
      hex_q     <= '0;
      dp_q      <= 1'b0;
      an_q      <= AN_IDLE;
      frame_q   <= 1'b0;
    end else begin
      sh_val_q  <= sh_val_d;
      sh_dp_q   <= sh_dp_d;
      sh_en_q   <= sh_en_d;
      act_val_q <= act_val_d;
      act_dp_q  <= act_dp_d;
      act_en_q  <= act_en_d;
      hex_q     <= hex_d;
      dp_q      <= dp_d;
      an_q      <= an_d;
      frame_q   <= frame_wrap;
    end
  end

  assign bus.HexDigit_O = hex_q;
  assign bus.Dp_O       = dp_q;
  assign bus.Led_AN_O   = an_q;
  assign bus.Frame_O    = frame_q;

endmodule

// File: tb/tb_seven_seg_scan_mux.sv
// tb/tb_seven_seg_scan_mux.sv - directed self-checking bench for seven_seg_scan_mux
module tb_seven_seg_scan_mux;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   fails  = 0;

  seven_seg_scan_mux_if #(.NUM_DIGITS(8)) bus ();

  seven_seg_scan_mux #(
    .NUM_DIGITS     (8),
    .TICKS_PER_DIGIT(8),
    .BLANK_TICKS    (2)
  ) dut (
    .Clk_I(clk),
    .Rst_I(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int j, input logic [7:0] an,
                     input logic [3:0] hx, input logic dp, input logic fr);
    checks++;
    assert (bus.Led_AN_O === an) else begin
      fails++;
      $error("FAIL %s anode step %0d got %h exp %h", tag, j, bus.Led_AN_O, an);
    end
    checks++;
    assert (bus.HexDigit_O === hx) else begin
      fails++;
      $error("FAIL %s hex step %0d got %h exp %h", tag, j, bus.HexDigit_O, hx);
    end
    checks++;
    assert (bus.Dp_O === dp) else begin
      fails++;
      $error("FAIL %s dp step %0d got %b exp %b", tag, j, bus.Dp_O, dp);
    end
    checks++;
    assert (bus.Frame_O === fr) else begin
      fails++;
      $error("FAIL %s frame step %0d got %b exp %b", tag, j, bus.Frame_O, fr);
    end
  endtask

  // Step j of a frame shows the state of tick (j-1)%8 in slot (j-1)/8.
  // an_tbl/hex_tbl/dp_tbl hold the hand-computed per-slot lit values, slot 0 in the LSBs.
  task automatic run_frame(input string tag, input logic [63:0] an_tbl,
                           input logic [31:0] hex_tbl, input logic [7:0] dp_tbl,
                           input int load_j, input logic [31:0] load_val,
                           input logic [7:0] load_en, input logic [7:0] load_dp,
                           input int nsteps);
    int         slot;
    int         t;
    logic [7:0] exp_an;
    logic       exp_dp;
    for (int j = 1; j <= nsteps; j++) begin
      if (j == load_j) begin
        bus.Value_I   = load_val;
        bus.DigitEn_I = load_en;
        bus.DpMask_I  = load_dp;
        bus.Load_I    = 1'b1;
      end
      step();
      bus.Load_I = 1'b0;
      slot   = (j - 1) / 8;
      t      = (j - 1) % 8;
      exp_an = (t < 2) ? 8'hFF : an_tbl[8*slot +: 8];
      exp_dp = (t < 2) ? 1'b0  : dp_tbl[slot];
      chk(tag, j, exp_an, hex_tbl[4*slot +: 4], exp_dp, j == 64);
    end
  endtask

  localparam logic [63:0] AN_ALL   = 64'h7FBF_DFEF_F7FB_FDFE;
  localparam logic [63:0] AN_DARK  = 64'hFFFF_FFFF_FFFF_FFFF;

  initial begin
    rst           = 1'b1;
    bus.Value_I   = '0;
    bus.Load_I    = 1'b0;
    bus.DpMask_I  = '0;
    bus.DigitEn_I = '0;
    bus.LzbEn_I   = 1'b0;
    repeat (3) step();
    chk("reset", 0, 8'hFF, 4'h0, 1'b0, 1'b0);
    rst = 1'b0;

    // Frame 0: nothing active yet; first Frame_O lands 64 cycles after release.
    run_frame("frame0", AN_DARK, 32'h0, 8'h00, 1, 32'h1234_5678, 8'hFF, 8'h00, 64);
    // Full scan of 12345678.
    run_frame("scan", AN_ALL, 32'h1234_5678, 8'h00, 1, 32'h0000_0A05, 8'hFF, 8'h00, 64);
    bus.LzbEn_I = 1'b1;
    // Leading-zero blanking: digits 0..2 lit.
    run_frame("lzb_a05", 64'hFFFF_FFFF_FFFB_FDFE, 32'h0000_0A05, 8'h00,
              1, 32'h0, 8'hFF, 8'h00, 64);
    // Value zero: only digit 0 lit.
    run_frame("lzb_zero", 64'hFFFF_FFFF_FFFF_FFFE, 32'h0, 8'h00,
              1, 32'h1234_5678, 8'hFF, 8'h00, 64);
    // Mid-frame load at slot 3 must not tear this frame.
    run_frame("dbuf_old", AN_ALL, 32'h1234_5678, 8'h00,
              28, 32'hFFFF_FFFF, 8'hFF, 8'h00, 64);
    // New value from the next frame; load on the wrap cycle bypasses the shadow.
    run_frame("dbuf_new", AN_ALL, 32'hFFFF_FFFF, 8'h00,
              64, 32'h8765_4321, 8'hFF, 8'h00, 64);
    run_frame("wrap_load", AN_ALL, 32'h8765_4321, 8'h00,
              1, 32'h8765_4321, 8'h0F, 8'h02, 64);
    // Digit enables 0F and DP on digit 1.
    run_frame("en_dp", 64'hFFFF_FFFF_F7FB_FDFE, 32'h8765_4321, 8'h02,
              0, 32'h0, 8'h00, 8'h00, 64);
    // Run into slot 5 tick 4, then reset for one cycle.
    run_frame("pre_rst", 64'hFFFF_FFFF_F7FB_FDFE, 32'h8765_4321, 8'h02,
              0, 32'h0, 8'h00, 8'h00, 44);
    rst = 1'b1;
    step();
    chk("mid_reset", 0, 8'hFF, 4'h0, 1'b0, 1'b0);
    rst = 1'b0;
    // Scan restarts from digit 0 with a cleared active buffer.
    run_frame("post_rst", AN_DARK, 32'h0, 8'h00, 0, 32'h0, 8'h00, 8'h00, 64);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
